// File: rtl/matrix_result_streamer_pkg.sv
// Shared constants and types for the matrix result streamer.
package matrix_result_streamer_pkg;

  localparam int unsigned ELEMENT_WIDTH   = 8;
  localparam int unsigned BRAM_ADDR_WIDTH = 10;
  localparam int unsigned DIM_WIDTH       = 4;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_LATCH,
    ST_EMIT,
    ST_SEP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/matrix_result_streamer_if.sv
// Control, BRAM read port and UART TX byte stream of the result streamer.
//   master: streamer side (drives done/busy/mem_rd_*/tx_data/tx_valid)
//   slave : controller/BRAM/UART side
interface matrix_result_streamer_if
  import matrix_result_streamer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BRAM_ADDR_WIDTH
);
  logic                     start;
  logic                     done;
  logic                     busy;
  logic [DIM_WIDTH-1:0]     dim_m;
  logic [DIM_WIDTH-1:0]     dim_n;
  logic [ADDR_WIDTH-1:0]    addr_base;
  logic                     mem_rd_en;
  logic [ADDR_WIDTH-1:0]    mem_rd_addr;
  logic [ELEMENT_WIDTH-1:0] mem_rd_data;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;

  modport master (
    input  start, dim_m, dim_n, addr_base, mem_rd_data, tx_ready,
    output done, busy, mem_rd_en, mem_rd_addr, tx_data, tx_valid
  );

  modport slave (
    output start, dim_m, dim_n, addr_base, mem_rd_data, tx_ready,
    input  done, busy, mem_rd_en, mem_rd_addr, tx_data, tx_valid
  );
endinterface

// File: rtl/matrix_result_streamer_u8_to_ascii.sv
// Combinational 8-bit unsigned to decimal ASCII converter.
//   value_i   : element value
//   hund_c_o  : hundreds digit (ASCII)
//   tens_c_o  : tens digit (ASCII)
//   units_c_o : units digit (ASCII)
//   count_c_o : significant digits, 1..3
module matrix_result_streamer_u8_to_ascii
  import matrix_result_streamer_pkg::*;
(
  input  logic [ELEMENT_WIDTH-1:0] value_i,
  output logic [7:0]               hund_c_o,
  output logic [7:0]               tens_c_o,
  output logic [7:0]               units_c_o,
  output logic [1:0]               count_c_o
);

  // Constant divisors map to small dividers in synthesis.
  always_comb begin
    hund_c_o  = CHAR_ZERO + 8'(value_i / 8'd100);
    tens_c_o  = CHAR_ZERO + 8'((value_i / 8'd10) % 8'd10);
    units_c_o = CHAR_ZERO + 8'(value_i % 8'd10);
    if (value_i >= 8'd100)     count_c_o = 2'd3;
    else if (value_i >= 8'd10) count_c_o = 2'd2;
    else                       count_c_o = 2'd1;
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Reads an M x N row-major matrix from BRAM and streams it as decimal ASCII
// text (space separated, CR LF per row) to the UART transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/done/busy, dims, BRAM read port, TX byte handshake
module matrix_result_streamer
  import matrix_result_streamer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BRAM_ADDR_WIDTH
)(
  input  logic                      clk,
  input  logic                      rst_n,
  matrix_result_streamer_if.master  bus
);

  state_e                 state_q, state_d;
  logic [DIM_WIDTH-1:0]   i_q, i_d, j_q, j_d;
  logic                   done_q, done_d, busy_q, busy_d;
  logic                   rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [7:0]             tx_data_q, tx_data_d;
  logic                   tx_valid_q, tx_valid_d;
  logic [7:0]             q0_q, q0_d, q1_q, q1_d;
  logic [1:0]             left_q, left_d;
  logic                   lf_q, lf_d;

  logic [7:0]             hund_c, tens_c, units_c, prod_c;
  logic [1:0]             cnt_c;
  logic                   tx_fire_c;
  logic [DIM_WIDTH-1:0]   last_i_c, last_j_c;

  matrix_result_streamer_u8_to_ascii u_conv (
    .value_i   (bus.mem_rd_data),
    .hund_c_o  (hund_c),
    .tens_c_o  (tens_c),
    .units_c_o (units_c),
    .count_c_o (cnt_c)
  );

  // Row offset is formed as an 8-bit product, then zero-extended.
  assign prod_c    = 8'(i_q) * 8'(bus.dim_n);
  assign tx_fire_c = tx_valid_q & bus.tx_ready;
  assign last_i_c  = bus.dim_m - DIM_WIDTH'(1);
  assign last_j_c  = bus.dim_n - DIM_WIDTH'(1);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      j_q        <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      q0_q       <= '0;
      q1_q       <= '0;
      left_q     <= '0;
      lf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      q0_q       <= q0_d;
      q1_q       <= q1_d;
      left_q     <= left_d;
      lf_q       <= lf_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    q0_d       = q0_q;
    q1_d       = q1_q;
    left_d     = left_q;
    lf_d       = lf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.dim_m == '0 || bus.dim_n == '0) begin
            state_d = ST_DONE;
          end else begin
            i_d     = '0;
            j_d     = '0;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        rd_en_d   = 1'b1;
        rd_addr_d = bus.addr_base + ADDR_WIDTH'(prod_c) + ADDR_WIDTH'(j_q);
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        rd_en_d = 1'b0;
        state_d = ST_LATCH;
      end
      // First digit goes straight to the TX register; the rest are queued.
      ST_LATCH: begin
        tx_valid_d = 1'b1;
        case (cnt_c)
          2'd3: begin
            tx_data_d = hund_c;
            q0_d      = tens_c;
            q1_d      = units_c;
            left_d    = 2'd2;
          end
          2'd2: begin
            tx_data_d = tens_c;
            q0_d      = units_c;
            left_d    = 2'd1;
          end
          default: begin
            tx_data_d = units_c;
            left_d    = 2'd0;
          end
        endcase
        state_d = ST_EMIT;
      end
      // Acceptance of the last digit presents the separator with no bubble.
      ST_EMIT: begin
        if (tx_fire_c) begin
          if (left_q != 2'd0) begin
            tx_data_d = q0_q;
            q0_d      = q1_q;
            left_d    = left_q - 2'd1;
          end else begin
            tx_data_d = (j_q == last_j_c) ? CHAR_CR : CHAR_SPACE;
            lf_d      = 1'b0;
            state_d   = ST_SEP;
          end
        end
      end
      // lf_q marks the second byte of a row terminator.
      ST_SEP: begin
        if (tx_fire_c) begin
          if (j_q != last_j_c) begin
            tx_valid_d = 1'b0;
            j_d        = j_q + DIM_WIDTH'(1);
            state_d    = ST_RD;
          end else if (!lf_q) begin
            tx_data_d = CHAR_LF;
            lf_d      = 1'b1;
          end else begin
            tx_valid_d = 1'b0;
            lf_d       = 1'b0;
            j_d        = '0;
            if (i_q == last_i_c) begin
              state_d = ST_DONE;
            end else begin
              i_d     = i_q + DIM_WIDTH'(1);
              state_d = ST_RD;
            end
          end
        end
      end
      // Waiting for start to drop prevents a held start from retriggering.
      ST_DONE: begin
        if (!bus.start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_rd_addr = rd_addr_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Self-checking bench for matrix_result_streamer.
module tb_matrix_result_streamer;
  import matrix_result_streamer_pkg::*;

  localparam int unsigned AW    = BRAM_ADDR_WIDTH;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_result_streamer_if #(.ADDR_WIDTH(AW)) bus();

  matrix_result_streamer #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Standalone converter for the exhaustive 0..255 sweep.
  logic [7:0] cv_val, cv_h, cv_t, cv_u;
  logic [1:0] cv_cnt;
  matrix_result_streamer_u8_to_ascii u_cv (
    .value_i   (cv_val),
    .hund_c_o  (cv_h),
    .tens_c_o  (cv_t),
    .units_c_o (cv_u),
    .count_c_o (cv_cnt)
  );

  logic [7:0]  mem [DEPTH];
  int unsigned ready_pct = 100;

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state (written only by the monitor process)
  logic [7:0] rx_q[$];
  int         rd_log[$];
  int         cyc = 0;
  int         hold_err = 0;
  int         tx_seen = 0;
  int         last_xfer_cyc = 0;
  int         done_rise_cyc = 0;
  bit         prev_stall = 1'b0;
  bit         prev_done = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // BRAM: one-cycle registered read
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
  end

  // UART ready: redrawn just after every rising edge
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Observe on the falling edge; a transfer is recorded for the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(bus.tx_valid && bus.tx_data == prev_data)) hold_err++;
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
    if (bus.tx_valid) tx_seen++;
    if (bus.tx_valid && bus.tx_ready) begin
      rx_q.push_back(bus.tx_data);
      last_xfer_cyc = cyc;
    end
    if (bus.mem_rd_en) rd_log.push_back(int'(bus.mem_rd_addr));
    if (bus.done && !prev_done) done_rise_cyc = cyc;
    prev_done = bus.done;
  end

  function automatic string esc(input string s);
    string r = "";
    for (int k = 0; k < s.len(); k++) begin
      if (r.len() > 200) begin
        r = {r, "..."};
        break;
      end
      if (s[k] == 8'h0D)      r = {r, "<CR>"};
      else if (s[k] == 8'h0A) r = {r, "<LF>"};
      else                    r = {r, $sformatf("%c", s[k])};
    end
    return r;
  endfunction

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got \"%s\", expected \"%s\"", name, esc(act), esc(exp));
  endtask

  // Reference text: each element in decimal, " " between, CR LF after each row.
  function automatic string model_stream(input int m, input int n, input int base);
    string s = "";
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        s = {s, $sformatf("%0d", mem[base + i*n + j])};
        s = {s, (j == n-1) ? "\r\n" : " "};
      end
    return s;
  endfunction

  function automatic string rx_from(input int from);
    string s = "";
    for (int k = from; k < rx_q.size(); k++) s = {s, $sformatf("%c", rx_q[k])};
    return s;
  endfunction

  task automatic run_stream(input string tag, input int m, input int n, input int base,
                            input int pct, input string exp, input int hold);
    int rx0, rd0, hold0, tx0, rdh, waited, mism, cnt;
    string want;
    ready_pct = pct;
    @(negedge clk);
    bus.dim_m     = 4'(m);
    bus.dim_n     = 4'(n);
    bus.addr_base = AW'(base);
    rx0   = rx_q.size();
    rd0   = rd_log.size();
    hold0 = hold_err;
    bus.start = 1'b1;
    waited = 0;
    while (!bus.done && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    check_val({tag, "_done_seen"}, 64'(bus.done), 64'd1);
    if (m == 0 || n == 0) check_val({tag, "_done_latency_le2"}, 64'(waited <= 2), 64'd1);
    @(negedge clk);
    want = (exp.len() != 0) ? exp : model_stream(m, n, base);
    check_str({tag, "_bytes"}, rx_from(rx0), want);
    cnt = rd_log.size() - rd0;
    check_val({tag, "_rd_count"}, 64'(cnt), 64'(m*n));
    mism = 0;
    for (int k = 0; k < cnt && k < m*n; k++)
      if (rd_log[rd0 + k] != base + (k / n) * n + (k % n)) mism++;
    check_val({tag, "_rd_addr_mism"}, 64'(mism), 64'd0);
    check_val({tag, "_hold_err"}, 64'(hold_err - hold0), 64'd0);
    if (m*n != 0) check_val({tag, "_done_after_lf"}, 64'(done_rise_cyc - last_xfer_cyc), 64'd1);
    if (hold > 0) begin
      tx0 = tx_seen;
      rdh = rd_log.size();
      repeat (hold) @(negedge clk);
      check_val({tag, "_no_retrigger"}, 64'((tx_seen - tx0) + (rd_log.size() - rdh)), 64'd0);
      check_val({tag, "_done_held"}, 64'(bus.done), 64'd1);
    end
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val({tag, "_idle"}, 64'({bus.done, bus.busy, bus.tx_valid}), 64'd0);
  endtask

  typedef struct {
    string name;
    int    m, n, base, pct, hold;
    int    load;     // 0 keep memory, 1 table values, 2 random
    int    vals[16];
    string exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int mism, rx0, waited, m, n, base;
    string got, want;

    bus.start = 1'b0; bus.dim_m = '0; bus.dim_n = '0; bus.addr_base = '0;
    for (int k = 0; k < int'(DEPTH); k++) mem[k] = 8'h00;

    // Converter sweep against printf formatting
    mism = 0;
    for (int v = 0; v < 256; v++) begin
      cv_val = 8'(v);
      #1;
      case (cv_cnt)
        2'd3:    got = $sformatf("%c%c%c", cv_h, cv_t, cv_u);
        2'd2:    got = $sformatf("%c%c", cv_t, cv_u);
        2'd1:    got = $sformatf("%c", cv_u);
        default: got = "?";
      endcase
      if (got != $sformatf("%0d", v)) mism++;
    end
    check_val("u8_to_ascii_sweep", 64'(mism), 64'd0);

    // Reset values
    repeat (2) @(negedge clk);
    check_val("reset_outputs",
              64'({bus.done, bus.busy, bus.mem_rd_en, bus.tx_valid, bus.mem_rd_addr, bus.tx_data}), 64'd0);
    rst_n = 1'b1;

    tbl[0] = '{name:"m2x2", m:2, n:2, base:'h10, pct:100, hold:0, load:1,
               vals:'{1,23,100,255,0,0,0,0,0,0,0,0,0,0,0,0}, exp:"1 23\r\n100 255\r\n"};
    tbl[1] = '{name:"m1x3", m:1, n:3, base:'h20, pct:100, hold:0, load:1,
               vals:'{0,9,10,0,0,0,0,0,0,0,0,0,0,0,0,0}, exp:"0 9 10\r\n"};
    tbl[2] = '{name:"m3x3_full", m:3, n:3, base:'h30, pct:100, hold:0, load:2,
               vals:'{default:0}, exp:""};
    tbl[3] = '{name:"m3x3_r30", m:3, n:3, base:'h30, pct:30, hold:0, load:0,
               vals:'{default:0}, exp:""};
    tbl[4] = '{name:"zero_m", m:0, n:5, base:'h50, pct:100, hold:0, load:0,
               vals:'{default:0}, exp:""};
    tbl[5] = '{name:"zero_n", m:3, n:0, base:'h50, pct:100, hold:0, load:0,
               vals:'{default:0}, exp:""};
    tbl[6] = '{name:"hold_start", m:2, n:3, base:'h60, pct:100, hold:20, load:2,
               vals:'{default:0}, exp:""};
    tbl[7] = '{name:"m15x15", m:15, n:15, base:'h100, pct:100, hold:0, load:2,
               vals:'{default:0}, exp:""};

    for (int t = 0; t < 8; t++) begin
      if (tbl[t].load == 1)
        for (int k = 0; k < 16; k++) mem[tbl[t].base + k] = 8'(tbl[t].vals[k]);
      else if (tbl[t].load == 2)
        for (int k = 0; k < tbl[t].m * tbl[t].n; k++) mem[tbl[t].base + k] = 8'($urandom_range(255));
      run_stream(tbl[t].name, tbl[t].m, tbl[t].n, tbl[t].base, tbl[t].pct, tbl[t].exp, tbl[t].hold);
      if (t == 6) run_stream("restart_after_hold", 2, 3, 'h60, 100, "", 0);
    end

    // Randomized streams against the text model
    for (int r = 0; r < 6; r++) begin
      m    = int'($urandom_range(1, 5));
      n    = int'($urandom_range(1, 5));
      base = int'($urandom_range(0, 900));
      for (int k = 0; k < m*n; k++) mem[base + k] = 8'($urandom_range(255));
      run_stream($sformatf("rand%0d", r), m, n, base, int'($urandom_range(20, 100)), "", 0);
    end

    // Reset in the middle of a 4x4 stream, then a clean restart
    for (int k = 0; k < 16; k++) mem['h200 + k] = 8'($urandom_range(100, 255));
    ready_pct = 100;
    @(negedge clk);
    bus.dim_m = 4'd4; bus.dim_n = 4'd4; bus.addr_base = AW'('h200);
    rx0 = rx_q.size();
    bus.start = 1'b1;
    waited = 0;
    while (rx_q.size() - rx0 < 6 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check_val("midstream_reached", 64'(rx_q.size() - rx0 >= 6), 64'd1);
    rst_n = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check_val("midstream_reset_outputs",
              64'({bus.done, bus.busy, bus.mem_rd_en, bus.tx_valid, bus.mem_rd_addr, bus.tx_data}), 64'd0);
    rst_n = 1'b1;
    run_stream("after_reset_4x4", 4, 4, 'h200, 100, "", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
